fsm_state_monitor: RTL
======================

// Module: fsm_state_monitor
// PURPOSE
//  Passive observer for a design FSM's state register. Each cycle it samples the state and
//  tracks which states were visited. It checks every state change against a legal-transition
//  table and measures dwell time in each state.
//  Exposes sticky error flags plus a single-request register read port for the testbench or
//  debug logic. Runtime counterpart to static unreachable-state and illegal-transition checks.
// PARAMETERS
//  STATE_W     2        width of observed state register
//  NUM_STATES  4        number of encodings, = 2**STATE_W
//  LEGAL_MAP   16'h0112 bit [from*NUM_STATES+to]=1 marks a legal change;
//                       default allows only 00->01, 01->00, 10->00
//  STALL_LIMIT 255      dwell cycles in one state that raise stall_err
//  CNT_W       16       width of event counters, saturating
// PORTS
//  clk          in   1             single clock, rising edge
//  rst          in   1             synchronous, active-high reset
//  mon_en       in   1             sample state_in this cycle when high
//  state_in     in   STATE_W       observed FSM current state
//  clear        in   1             synchronous clear of all statistics and flags
//  rd_req       in   1             read request, single-cycle pulse
//  rd_addr      in   3             register select
//  rd_ack       out  1             read data valid, one cycle
//  rd_data      out  32            read data, zero-extended
//  visited      out  NUM_STATES    bit i set once state i has been sampled
//  illegal_err  out  1             sticky, set on first illegal change
//  stall_err    out  1             sticky, set when dwell reaches STALL_LIMIT
// BEHAVIOUR
//  Reset: all outputs 0. Counters 0. Monitor FSM goes to IDLE.
//  Monitor FSM:
//   IDLE  -> ARMED on first mon_en=1. That sample sets visited[state_in] and loads prev.
//   ARMED -> TRACK on the next sampled cycle.
//   TRACK compares state_in against prev on every cycle with mon_en=1.
//   mon_en=0 in ARMED/TRACK: hold everything, with no dwell increment.
//  In TRACK, per sample:
//   state_in==prev: dwell++, saturating at 2**CNT_W-1.
//   state_in!=prev: trans_cnt++ and dwell<=1. max_dwell<=max(max_dwell,dwell).
//   A change with LEGAL_MAP[prev*NUM_STATES+state_in]==0 does illegal_cnt++ and sets
//   illegal_err. The first such change is latched into first_bad={prev,state_in}; later
//   illegal changes do not overwrite it.
//   Self-loops are always legal.
//   dwell==STALL_LIMIT sets stall_err, once per dwell episode.
//  All flag and counter updates are registered: visible the cycle after the sample.
//  clear: returns counters, flags, visited and first_bad to 0 and the FSM to IDLE next cycle.
//   Same-cycle sample is discarded. rst has priority over clear.
//  Read port:
//   rd_req in cycle N gives rd_ack=1 in cycle N+1, with rd_data taken from values at cycle N
//   (pre-update, pre-clear).
//   Back-to-back requests are allowed; one ack per request.
//   Address map: 0 visited, 1 trans_cnt, 2 illegal_cnt, 3 first_bad, 4 max_dwell,
//   5 {stall_err,illegal_err}, 6 ~visited (unreached mask), 7 reads 0.
//  Reset mid-operation drops any pending ack.
// STRUCTURE
//  fsm_mon_pkg: monitor state typedef (IDLE/ARMED/TRACK), read-address localparams
//  ADDR_VISITED..ADDR_UNREACHED, default LEGAL_MAP.
//  Sub-module sat_counter (params W; ports clk, rst, clr, inc, load1, q), instanced for
//  dwell, trans_cnt and illegal_cnt.
//  Remainder stays flat in fsm_state_monitor.
// TESTING
//  1. rst 2 cycles; mon_en=1; state 00,01,00,01
//     -> visited=4'b0011, trans_cnt=3, illegal_err=0; addr6 reads 32'hC.
//  2. state 00,01,10 -> illegal_err=1 one cycle after the 10 sample; addr3 reads 32'h6;
//     a later 10->11 change leaves addr3 at 32'h6.
//  3. Hold state 10 for 255 samples -> stall_err=1 on cycle 256; addr4 reads 0 until a
//     change, then 255.
//  4. mon_en low for 10 cycles mid-stream -> dwell and counters unchanged, no illegal flag
//     from the gap.
//  5. rd_req+clear in the same cycle with trans_cnt=5
//     -> rd_ack next cycle with rd_data=5; all stats 0 after.
//  6. rst asserted during TRACK with rd_req pending
//     -> rd_ack=0 next cycle, visited=0, FSM back in IDLE.

Source files
------------

// File: rtl/fsm_mon_pkg.sv
// Shared types and constants for the FSM state monitor: monitor states,
// read-port register map and the default legal-transition table.
package fsm_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2
  } mon_state_t;

  localparam logic [2:0] ADDR_VISITED   = 3'd0;
  localparam logic [2:0] ADDR_TRANS     = 3'd1;
  localparam logic [2:0] ADDR_ILLEGAL   = 3'd2;
  localparam logic [2:0] ADDR_FIRST_BAD = 3'd3;
  localparam logic [2:0] ADDR_MAX_DWELL = 3'd4;
  localparam logic [2:0] ADDR_FLAGS     = 3'd5;
  localparam logic [2:0] ADDR_UNREACHED = 3'd6;

  // Legal changes: 00->01, 01->00, 10->00.
  localparam logic [15:0] DEFAULT_LEGAL_MAP = 16'h0112;

endpackage

// File: rtl/fsm_state_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset/clear and a load-to-one
// input used to restart an episode count.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         load1,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load1) begin
      q <= W'(1);
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/fsm_state_monitor.sv
// Passive observer of an FSM state register: visited-state tracking,
// legal-transition checking, dwell measurement and a one-cycle read port.
module fsm_state_monitor
  import fsm_mon_pkg::*;
#(
  parameter int unsigned STATE_W     = 2,
  parameter int unsigned NUM_STATES  = 4,
  parameter logic [NUM_STATES*NUM_STATES-1:0] LEGAL_MAP = DEFAULT_LEGAL_MAP,
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mon_en,
  input  logic [STATE_W-1:0]    state_in,
  input  logic                  clear,
  input  logic                  rd_req,
  input  logic [2:0]            rd_addr,
  output logic                  rd_ack,
  output logic [31:0]           rd_data,
  output logic [NUM_STATES-1:0] visited,
  output logic                  illegal_err,
  output logic                  stall_err
);

  mon_state_t              r_state;
  mon_state_t              w_state_next;
  logic [STATE_W-1:0]      r_prev;
  logic [NUM_STATES-1:0]   r_visited;
  logic [2*STATE_W-1:0]    r_first_bad;
  logic [CNT_W-1:0]        r_max_dwell;
  logic                    r_illegal_err;
  logic                    r_stall_err;
  logic                    r_rd_ack;
  logic [31:0]             r_rd_data;

  logic [CNT_W-1:0]        w_dwell;
  logic [CNT_W-1:0]        w_trans_cnt;
  logic [CNT_W-1:0]        w_illegal_cnt;
  logic [CNT_W-1:0]        w_dwell_next;
  logic [NUM_STATES-1:0]   w_unreached;
  logic [31:0]             w_rd_mux;
  logic                    w_first;
  logic                    w_cmp;
  logic                    w_change;
  logic                    w_same;
  logic                    w_illegal;
  logic                    w_sample;
  logic                    w_stall_hit;

  // The arming sample (ARMED) is already compared against prev, so it can
  // count the very first change after leaving IDLE.
  assign w_first   = mon_en && (r_state == ST_IDLE);
  assign w_cmp     = mon_en && (r_state != ST_IDLE);
  assign w_change  = w_cmp && (state_in != r_prev);
  assign w_same    = w_cmp && (state_in == r_prev);
  assign w_illegal = w_change && !LEGAL_MAP[{r_prev, state_in}];
  assign w_sample  = w_first || w_cmp;

  always_comb begin
    w_dwell_next = w_dwell;
    if (w_first || w_change) begin
      w_dwell_next = CNT_W'(1);
    end else if (w_same && (w_dwell != '1)) begin
      w_dwell_next = w_dwell + CNT_W'(1);
    end
  end

  assign w_stall_hit = w_sample && (w_dwell_next == CNT_W'(STALL_LIMIT));

  sat_counter #(.W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (w_same),
    .load1 (w_first || w_change),
    .q     (w_dwell)
  );

  sat_counter #(.W(CNT_W)) u_trans_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (w_change),
    .load1 (1'b0),
    .q     (w_trans_cnt)
  );

  sat_counter #(.W(CNT_W)) u_illegal_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (w_illegal),
    .load1 (1'b0),
    .q     (w_illegal_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (mon_en) w_state_next = ST_ARMED;
      ST_ARMED: if (mon_en) w_state_next = ST_TRACK;
      ST_TRACK: w_state_next = ST_TRACK;
      default:  w_state_next = ST_IDLE;
    endcase
    if (clear) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_prev        <= '0;
      r_visited     <= '0;
      r_first_bad   <= '0;
      r_max_dwell   <= '0;
      r_illegal_err <= 1'b0;
      r_stall_err   <= 1'b0;
    end else begin
      if (w_sample) begin
        r_visited[state_in] <= 1'b1;
      end
      if (w_first || w_change) begin
        r_prev <= state_in;
      end
      if (w_change && (w_dwell > r_max_dwell)) begin
        r_max_dwell <= w_dwell;
      end
      if (w_illegal) begin
        r_illegal_err <= 1'b1;
        if (!r_illegal_err) begin
          r_first_bad <= {r_prev, state_in};
        end
      end
      if (w_stall_hit) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign w_unreached = ~r_visited;

  always_comb begin
    w_rd_mux = '0;
    case (rd_addr)
      ADDR_VISITED:   w_rd_mux = 32'(r_visited);
      ADDR_TRANS:     w_rd_mux = 32'(w_trans_cnt);
      ADDR_ILLEGAL:   w_rd_mux = 32'(w_illegal_cnt);
      ADDR_FIRST_BAD: w_rd_mux = 32'(r_first_bad);
      ADDR_MAX_DWELL: w_rd_mux = 32'(r_max_dwell);
      ADDR_FLAGS:     w_rd_mux = 32'({r_stall_err, r_illegal_err});
      ADDR_UNREACHED: w_rd_mux = 32'(w_unreached);
      default:        w_rd_mux = '0;
    endcase
  end

  // Read data is captured from pre-update values and is unaffected by clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign rd_ack      = r_rd_ack;
  assign rd_data     = r_rd_data;
  assign visited     = r_visited;
  assign illegal_err = r_illegal_err;
  assign stall_err   = r_stall_err;

endmodule
